// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch and load/store ports.
// Data requests win by default; a run counter forces a fetch grant after MAX_DATA_RUN data grants.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [3:0]        d_be_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_e;

  localparam logic [1:0] LatInit = 2'(RD_LAT - 1);
  localparam logic [3:0] RunMax  = 4'(MAX_DATA_RUN);

  state_e state_q, state_d;
  logic   owner_data_q, owner_data_d;
  logic   store_q, store_d;
  logic [1:0] lat_q, lat_d;
  logic [3:0] run_q, run_d;

  logic              if_gnt_q, if_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_gnt_q, d_gnt_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

  logic data_wins;

  // Fetch only overtakes a pending data request once the data run has hit its limit.
  assign data_wins = d_req_i && !(if_req_i && (run_q == RunMax));

  // Outputs are computed one cycle ahead so that every port leaves a flop.
  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    store_d      = store_q;
    lat_d        = lat_q;
    run_d        = run_q;
    if_gnt_d     = 1'b0;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_gnt_d      = 1'b0;
    d_rvalid_d   = 1'b0;
    d_rdata_d    = d_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 4'b0000;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (data_wins) begin
          owner_data_d = 1'b1;
          store_d      = d_we_i;
          d_gnt_d      = 1'b1;
          mem_en_d     = 1'b1;
          mem_we_d     = d_we_i ? d_be_i : 4'b0000;
          mem_addr_d   = d_addr_i;
          mem_wdata_d  = d_wdata_i;
          run_d        = if_req_i ? ((run_q == RunMax) ? run_q : run_q + 4'd1) : 4'd0;
          state_d      = ACC;
        end else if (if_req_i) begin
          owner_data_d = 1'b0;
          store_d      = 1'b0;
          if_gnt_d     = 1'b1;
          mem_en_d     = 1'b1;
          mem_addr_d   = if_addr_i;
          run_d        = 4'd0;
          state_d      = ACC;
        end
      end
      ACC: begin
        if (store_q) begin
          state_d = IDLE;
        end else begin
          lat_d   = LatInit;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == 2'd0) begin
          if (owner_data_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_rdata_i;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
          state_d = RESP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      store_q      <= 1'b0;
      lat_q        <= 2'd0;
      run_q        <= 4'd0;
      if_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      d_gnt_q      <= 1'b0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      store_q      <= store_d;
      lat_q        <= lat_d;
      run_q        <= run_d;
      if_gnt_q     <= if_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_gnt_q      <= d_gnt_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign if_gnt_o    = if_gnt_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_gnt_o     = d_gnt_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a directed vector table, hand-written corner sequences, and random
// traffic compared every cycle against a transaction-timestamp model of the arbiter and memory.
module tb_mem_arbiter;

  localparam int Lat    = 3;
  localparam int MaxRun = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        ifGnt, ifRvalid;
  logic [31:0] ifRdata;
  logic        dReq, dWe;
  logic [31:0] dAddr, dWdata;
  logic [3:0]  dBe;
  logic        dGnt, dRvalid;
  logic [31:0] dRdata;
  logic        memEn;
  logic [3:0]  memWe;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(Lat), .MAX_DATA_RUN(MaxRun)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(ifReq), .if_addr_i(ifAddr), .if_gnt_o(ifGnt), .if_rvalid_o(ifRvalid), .if_rdata_o(ifRdata),
    .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata), .d_be_i(dBe),
    .d_gnt_o(dGnt), .d_rvalid_o(dRvalid), .d_rdata_o(dRdata),
    .mem_en_o(memEn), .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata), .busy_o(busy)
  );

  // Model state: one transaction at a time, described by its grant cycle and kind.
  logic [31:0] memArr [256];
  int          cyc = -1;
  int          nChecks = 0;
  int          nFail = 0;
  int          freeEdge = 0;
  int          dataRun = 0;
  bit          txActive = 1'b0;
  bit          txData = 1'b0;
  bit          txStore = 1'b0;
  int          txS = 0;
  logic [31:0] txAddr = '0, txWdata = '0, txWord = '0;
  logic [3:0]  txBe = '0;
  logic        expIfGnt = 1'b0, expDGnt = 1'b0, expIfRv = 1'b0, expDRv = 1'b0;
  logic        expMemEn = 1'b0, expBusy = 1'b0;
  logic [3:0]  expMemWe = '0;
  logic [31:0] expIfRdata = '0, expDRdata = '0;

  typedef struct {
    bit          isData;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  expMemWe;
    bit          expRv;
    logic [31:0] expRdata;
    int          busyOff;
  } vec_t;

  vec_t vecs[6];

  // Compares one value, counts it, and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  // Advances one clock: updates the model from the inputs sampled at this edge, drives the
  // memory read data for the new cycle, then compares every output at the falling edge.
  task automatic stepCycle();
    int rvCyc;
    int endCyc;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      txActive   = 1'b0;
      freeEdge   = cyc + 1;
      dataRun    = 0;
      expIfRdata = '0;
      expDRdata  = '0;
    end else if (cyc >= freeEdge && (ifReq || dReq)) begin
      txData  = dReq && !(ifReq && dataRun == MaxRun);
      txStore = txData && dWe;
      txAddr  = txData ? dAddr : ifAddr;
      txWdata = dWdata;
      txBe    = dBe;
      txS     = cyc;
      txActive = 1'b1;
      if (txData && ifReq) dataRun = (dataRun < MaxRun) ? dataRun + 1 : MaxRun;
      else dataRun = 0;
      if (txStore) begin
        for (int b = 0; b < 4; b++)
          if (txBe[b]) memArr[txAddr[9:2]][8*b +: 8] = txWdata[8*b +: 8];
        freeEdge = cyc + 2;
      end else begin
        txWord   = memArr[txAddr[9:2]];
        freeEdge = cyc + 3 + Lat;
      end
    end

    rvCyc    = txS + 1 + Lat;
    endCyc   = txStore ? txS : rvCyc;
    expMemEn = txActive && (cyc == txS);
    expIfGnt = expMemEn && !txData;
    expDGnt  = expMemEn && txData;
    expMemWe = (expMemEn && txStore) ? txBe : 4'b0000;
    expBusy  = txActive && (cyc >= txS) && (cyc <= endCyc);
    expIfRv  = txActive && !txStore && !txData && (cyc == rvCyc);
    expDRv   = txActive && !txStore && txData && (cyc == rvCyc);
    if (expIfRv) expIfRdata = txWord;
    if (expDRv) expDRdata = txWord;

    #1;
    memRdata = (txActive && !txStore && cyc == txS + Lat) ? txWord : $urandom;

    @(negedge clk);
    checkOutput("if_gnt", ifGnt, expIfGnt);
    checkOutput("d_gnt", dGnt, expDGnt);
    checkOutput("if_rvalid", ifRvalid, expIfRv);
    checkOutput("d_rvalid", dRvalid, expDRv);
    checkOutput("if_rdata", ifRdata, expIfRdata);
    checkOutput("d_rdata", dRdata, expDRdata);
    checkOutput("mem_en", memEn, expMemEn);
    checkOutput("mem_we", memWe, expMemWe);
    checkOutput("busy", busy, expBusy);
    if (expMemEn) begin
      checkOutput("mem_addr", memAddr, txAddr);
      if (txStore) checkOutput("mem_wdata", memWdata, txWdata);
    end
  endtask

  // Random requesters: hold until granted, sometimes withdraw, sometimes re-request at once.
  task automatic applyStimulus();
    rst = ($urandom_range(0, 249) != 0);
    if (expIfGnt) begin
      ifReq  = ($urandom_range(0, 3) == 0);
      ifAddr = $urandom;
    end else if (ifReq) begin
      if ($urandom_range(0, 15) == 0) ifReq = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      ifReq  = 1'b1;
      ifAddr = $urandom;
    end
    if (expDGnt || (!dReq && $urandom_range(0, 1) == 0)) begin
      dReq   = expDGnt ? ($urandom_range(0, 2) == 0) : 1'b1;
      dWe    = 1'($urandom_range(0, 1));
      dAddr  = $urandom;
      dWdata = $urandom;
      dBe    = 4'($urandom);
    end else if (dReq && $urandom_range(0, 15) == 0) begin
      dReq = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int nGr;
    int rvCount;
    int extra;
    logic [9:0] order;

    for (int i = 0; i < 256; i++) memArr[i] = $urandom;
    memArr[8'h04] = 32'h00500093;
    memArr[8'h40] = 32'h11223344;
    memArr[8'h80] = 32'h12345678;

    vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        4'h0,    4'h0,    1'b1, 32'h00500093, 5};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, 4'b0011, 1'b0, 32'h0,        1};
    vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'hF,    4'h0,    1'b1, 32'h1122BEEF, 5};
    vecs[3] = '{1'b1, 1'b1, 32'h200, 32'hFFFFFFFF, 4'b0000, 4'b0000, 1'b0, 32'h0,        1};
    vecs[4] = '{1'b1, 1'b0, 32'h200, 32'h0,        4'h0,    4'h0,    1'b1, 32'h12345678, 5};
    vecs[5] = '{1'b0, 1'b0, 32'h200, 32'h0,        4'h0,    4'h0,    1'b1, 32'h12345678, 5};

    rst = 1'b0; ifReq = 1'b0; ifAddr = '0; dReq = 1'b0; dWe = 1'b0;
    dAddr = '0; dWdata = '0; dBe = '0; memRdata = '0;
    repeat (3) stepCycle();
    checkOutput("reset_flags", {ifGnt, dGnt, ifRvalid, dRvalid, memEn, memWe, busy}, 32'h0);
    checkOutput("reset_data", ifRdata | dRdata | memAddr | memWdata, 32'h0);
    rst = 1'b1;
    stepCycle();

    // Isolated single transactions from the vector table.
    for (int i = 0; i < 6; i++) begin
      ifReq = !vecs[i].isData; ifAddr = vecs[i].addr;
      dReq = vecs[i].isData; dWe = vecs[i].we; dAddr = vecs[i].addr;
      dWdata = vecs[i].wdata; dBe = vecs[i].be;
      stepCycle();
      checkOutput("vec_gnt", {ifGnt, dGnt}, vecs[i].isData ? 2'b01 : 2'b10);
      checkOutput("vec_mem_en", memEn, 1);
      checkOutput("vec_mem_we", memWe, vecs[i].expMemWe);
      checkOutput("vec_mem_addr", memAddr, vecs[i].addr);
      checkOutput("vec_busy_gnt", busy, 1);
      if (vecs[i].we) checkOutput("vec_mem_wdata", memWdata, vecs[i].wdata);
      ifReq = 1'b0; dReq = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        stepCycle();
        if (k == 1 + Lat) begin
          checkOutput("vec_rvalid", {ifRvalid, dRvalid},
                      vecs[i].expRv ? (vecs[i].isData ? 2'b01 : 2'b10) : 2'b00);
          if (vecs[i].expRv)
            checkOutput("vec_rdata", vecs[i].isData ? dRdata : ifRdata, vecs[i].expRdata);
        end
        if (k < vecs[i].busyOff) checkOutput("vec_busy_hi", busy, 1);
        if (k == vecs[i].busyOff) checkOutput("vec_busy_lo", busy, 0);
      end
    end

    // Simultaneous fetch and load: data first, fetch in the following idle slot.
    ifReq = 1'b1; ifAddr = 32'h10; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h200;
    stepCycle();
    checkOutput("both_first_gnt", {ifGnt, dGnt}, 2'b01);
    dReq = 1'b0;
    repeat (1 + Lat) stepCycle();
    checkOutput("both_d_rvalid", dRvalid, 1);
    checkOutput("both_d_rdata", dRdata, 32'h12345678);
    stepCycle();
    stepCycle();
    checkOutput("both_then_fetch", {ifGnt, dGnt}, 2'b10);
    ifReq = 1'b0;
    repeat (5) stepCycle();

    // Both ports held with back-to-back stores: the run limit must let fetch through.
    ifReq = 1'b1; ifAddr = 32'h10; dReq = 1'b1; dWe = 1'b1;
    dAddr = 32'h300; dWdata = 32'hA5A5A5A5; dBe = 4'hF;
    nGr = 0; order = '0;
    for (int c = 0; c < 200 && nGr < 10; c++) begin
      stepCycle();
      if (ifGnt || dGnt) begin
        order = {order[8:0], ifGnt};
        nGr++;
      end
    end
    checkOutput("starve_count", nGr, 10);
    checkOutput("starve_order", {22'h0, order}, {22'h0, 10'b0000100001});
    ifReq = 1'b0; dReq = 1'b0;
    repeat (6) stepCycle();

    // Reset while a fetch is waiting on memory, then a fresh fetch.
    ifReq = 1'b1; ifAddr = 32'h10;
    stepCycle();
    checkOutput("rst_fetch_gnt", ifGnt, 1);
    ifReq = 1'b0;
    stepCycle();
    rst = 1'b0;
    stepCycle();
    checkOutput("rst_flags_zero", {ifGnt, dGnt, ifRvalid, dRvalid, memEn, memWe, busy}, 32'h0);
    checkOutput("rst_data_zero", ifRdata | dRdata | memAddr | memWdata, 32'h0);
    rst = 1'b1;
    rvCount = 0;
    repeat (6) begin
      stepCycle();
      rvCount += ifRvalid;
    end
    checkOutput("rst_no_rvalid", rvCount, 0);
    ifReq = 1'b1; ifAddr = 32'h10;
    stepCycle();
    ifReq = 1'b0;
    repeat (Lat) stepCycle();
    checkOutput("rst_fresh_early", ifRvalid, 0);
    stepCycle();
    checkOutput("rst_fresh_rvalid", ifRvalid, 1);
    checkOutput("rst_fresh_rdata", ifRdata, 32'h00500093);
    stepCycle();

    // A one-cycle data request while a fetch is in WAIT is withdrawn and never served.
    ifReq = 1'b1; ifAddr = 32'h20;
    stepCycle();
    ifReq = 1'b0;
    stepCycle();
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h40;
    stepCycle();
    dReq = 1'b0;
    extra = 0;
    repeat (8) begin
      stepCycle();
      extra += dGnt + memEn;
    end
    checkOutput("pulse_never_granted", extra, 0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequencer/arbiter that shares one single-port word-wide memory between two requesters: the instruction-fetch port and the load/store data port.
- Issues exactly one memory access at a time and waits a fixed read latency.
- Returns read data to the requester that owns the access.
- Uses data-priority arbitration with a starvation guard, so fetch is never locked out by a long run of loads/stores.

Parameters:
- ADDR_W, 32, address width of both ports and of the memory.
- DATA_W, 32, data width; fixed at 32, so byte enables are 4 bits.
- RD_LAT, 1, memory read latency in cycles, from the mem_en cycle to mem_rdata valid; legal range 1..4.
- MAX_DATA_RUN, 4, maximum consecutive data grants while if_req is pending; legal range 1..15.

Ports:
- clk  in  1  clock; all logic updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_gnt  out  1  one-cycle pulse; fetch access issued.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  4  store byte enables; ignored for loads.
- d_gnt  out  1  one-cycle pulse; data access issued.
- d_rvalid  out  1  one-cycle pulse, loads only.
- d_rdata  out  DATA_W  load word.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  per-byte write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the mem_en cycle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.

Reset:
- rst low at a posedge gives state = IDLE and run_cnt = 0.
- All outputs go to 0: gnt, rvalid, rdata, mem_*, busy.
- Reset mid-access aborts the access; no rvalid is ever produced for it.

States:
- IDLE:
  - Samples requests.
  - No request: stay in IDLE.
  - Otherwise: register the winner, its address, wdata and we, then go to ACC.
- ACC (1 cycle):
  - mem_en = 1.
  - mem_we = d_be if the winner is a data store, else 4'b0000.
  - The winner's gnt = 1.
  - Store: next state is IDLE.
  - Load/fetch: next state is WAIT with lat_cnt = RD_LAT-1.
- WAIT:
  - mem_en = 0.
  - Decrement lat_cnt.
  - When lat_cnt == 0, capture mem_rdata (which is the cycle ACC+RD_LAT) and go to RESP.
- RESP (1 cycle):
  - The owner's rvalid = 1, and its rdata holds the captured word.
  - Next state is IDLE.

Latency:
- Read: req sampled at edge N gives gnt in cycle N+1 and rvalid in cycle N+2+RD_LAT.
- Store: the next access can be granted no earlier than 2 cycles after the previous gnt.

Arbitration (evaluated in IDLE only):
- Only d_req: data wins. Only if_req: fetch wins.
- Both requesting: data wins unless run_cnt == MAX_DATA_RUN, in which case fetch wins.

run_cnt update:
- Data grant with if_req high: run_cnt + 1, saturating at MAX_DATA_RUN.
- Data grant with if_req low: run_cnt = 0.
- Fetch grant: run_cnt = 0.

Handshake rules:
- A requester must deassert req, or present a new request, in the cycle after its gnt.
- A req still high in a later IDLE cycle is a new request.
- Dropping req before gnt is legal; a withdrawn req is never granted.
- Address and data are sampled only at the IDLE→ACC edge.

Edge cases:
- Store with d_be = 0: granted, mem_en = 1, mem_we = 0 (no-op), no rvalid.
- rdata outputs hold their last value between rvalid pulses.
- Each port's rdata updates only on its own rvalid.
- mem_addr and mem_wdata may hold stale values when mem_en = 0.

Test Plan:
- RD_LAT=1; if_req with if_addr = 0x10, mem_rdata = 0x00500093 → if_gnt and mem_en with mem_addr = 0x10, mem_we = 0 in cycle 1; if_rvalid with if_rdata = 0x00500093 in cycle 3; busy high in cycles 1–3.
- Store: d_addr = 0x100, d_wdata = 0xDEADBEEF, d_be = 4'b0011 → one mem_en cycle with mem_we = 0011 and mem_wdata = 0xDEADBEEF; no d_rvalid; busy low 2 cycles after the sample.
- if_req and d_req both rise in the same cycle, load at 0x200 returning 0x12345678 → data granted first and d_rvalid carries 0x12345678; fetch granted in the next IDLE.
- MAX_DATA_RUN=4; if_req and d_req held continuously with stores → grant order D,D,D,D,I,D,D,D,D,I.
- RD_LAT=3; rst driven low during WAIT of a fetch → no if_rvalid; all outputs 0 on the next cycle; a fresh request afterwards gives rvalid 5 cycles after its sample.
- d_req pulsed for one cycle while the arbiter is in WAIT → never granted; no mem_en is produced for it.
